// File: rtl/round_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : round_key_scheduler
// Description : Iterative AES-128 key-schedule controller. Expands a cipher
//               key into round keys 0..NR at one key per clock using a single
//               key-expansion step, and stores every round key in an internal
//               bank that the round engine reads by index.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset (clears FSM and bank)
//               start   - request expansion of key_in (ignored while busy)
//               key_in  - 128-bit cipher key, sampled on the accept edge only
//               busy    - high while an expansion is in progress (NR cycles)
//               done    - one-cycle pulse, full bank written
//               valid   - bank contents match the last accepted key
//               rd_idx  - round-key read index
//               rd_key  - bank[rd_idx], zero when rd_idx > NR (combinational)
// Options     : KEY_CACHE_EN - when defined, an accepted start whose key
//               equals bank[0] while valid=1 skips re-expansion and reports
//               done on the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module round_key_scheduler #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [127:0]       key_in,
    output logic               busy,
    output logic               done,
    output logic               valid,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [127:0]       rd_key
);

    localparam logic [IDX_W-1:0] NR_IDX  = IDX_W'(NR);
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic. The S-box is derived arithmetically (multiplicative
    // inverse followed by the affine transform) instead of a lookup table.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for the step that produces round key idx: x^(idx-1).
    function automatic logic [7:0] rcon_for(input logic [IDX_W-1:0] idx);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 2; k <= NR; k++) begin
            if (k <= int'(idx)) r = xtime(r);
        end
        return r;
    endfunction

    // One AES-128 expansion step: round key i -> round key i+1.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = w0 ^ sub ^ {rc, 24'h000000};
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    cnt;
    logic [IDX_W-1:0]    cnt_nxt;
    logic                valid_r;
    logic                valid_nxt;
    logic                load;
    logic                step_we;
    logic                cache_hit;
    logic [IDX_W-1:0]    prev_idx;
    logic [127:0]        step_key;
    logic [127:0]        bank [0:NR];

`ifdef KEY_CACHE_EN
    // Same key as the one already expanded: the bank is reusable as-is.
    assign cache_hit = valid_r && (key_in == bank[0]);
`else
    assign cache_hit = 1'b0;
`endif

    // cnt is 0 outside EXPAND; clamp so the source index stays in range.
    assign prev_idx = (cnt == '0) ? '0 : (cnt - ONE_IDX);
    assign step_key = key_step(bank[prev_idx], rcon_for(cnt));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            valid_r <= valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = valid_r;
        load      = 1'b0;
        step_we   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    if (cache_hit) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_EXPAND;
                        cnt_nxt   = ONE_IDX;
                        valid_nxt = 1'b0;
                        load      = 1'b1;
                    end
                end
            end
            S_EXPAND: begin
                step_we = 1'b1;
                if (cnt == NR_IDX) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE_IDX;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Round-key bank. Reset wipes every entry so no partial result survives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                bank[i] <= '0;
            end
        end else if (load) begin
            bank[0] <= key_in;
        end else if (step_we) begin
            bank[cnt] <= step_key;
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= NR_IDX) begin
            rd_key = bank[rd_idx];
        end
    end

    assign busy  = (state == S_EXPAND);
    assign done  = (state == S_DONE);
    assign valid = valid_r;

endmodule
`default_nettype wire

// File: tb/tb_round_key_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_round_key_scheduler
// Description : Self-checking bench for round_key_scheduler. A reference
//               model predicts accept edges and done timing and queues the
//               expected key; a monitor checks status every cycle and sweeps
//               the whole bank whenever done is presented. Expected round
//               keys come from a textbook word-wise AES-128 expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_key_scheduler;

    localparam int NR    = 10;
    localparam int IDX_W = 4;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [127:0]       key_in;
    logic               busy;
    logic               done;
    logic               valid;
    logic [IDX_W-1:0]   rd_idx = '0;
    logic [127:0]       rd_key;

    always #5 clk = ~clk;

    round_key_scheduler #(.NR(NR), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .key_in (key_in),
        .busy   (busy),
        .done   (done),
        .valid  (valid),
        .rd_idx (rd_idx),
        .rd_key (rd_key)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference AES-128 key expansion (tables built by exhaustive search)
    // ------------------------------------------------------------------
    logic [7:0]   sbox_t  [0:255];
    logic [7:0]   rcon_t  [1:10];
    logic [127:0] exp_keys [0:NR];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        logic [7:0] y;
        acc = 8'h00;
        x = a;
        y = b;
        while (y != 0) begin
            if (y[0]) acc = acc ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return acc;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        logic [7:0] rc;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_t[x] = s;
        end
        rc = 8'h01;
        for (int j = 1; j <= 10; j++) begin
            rcon_t[j] = rc;
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_t[temp[31:24]], sbox_t[temp[23:16]],
                        sbox_t[temp[15:8]],  sbox_t[temp[7:0]]};
                temp = temp ^ {rcon_t[i/4], 24'h000000};
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= NR; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: which starts are accepted and when done is due
    // ------------------------------------------------------------------
    typedef struct {
        logic [127:0] key;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    int           cyc       = 0;
    int           remaining = 0;
    bit           m_valid   = 1'b0;
    logic [127:0] m_bank0   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining = 0;
            m_valid   = 1'b0;
            m_bank0   = '0;
            sbq.delete();
        end else begin
            cyc++;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) m_valid = 1'b1;
            end else if (start) begin : accept
                bit hit;
                hit = 1'b0;
`ifdef KEY_CACHE_EN
                hit = m_valid && (key_in == m_bank0);
`endif
                if (hit) begin
                    sbq.push_back('{key: key_in, due: cyc});
                end else begin
                    sbq.push_back('{key: key_in, due: cyc + NR});
                    remaining = NR;
                    m_valid   = 1'b0;
                    m_bank0   = key_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: status every cycle, full bank sweep on each done
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon
        exp_t         e;
        logic [127:0] want;
        bit           exp_done;
        if (!rst_n) begin
            check("rst_busy",  {127'b0, busy},  128'd0);
            check("rst_done",  {127'b0, done},  128'd0);
            check("rst_valid", {127'b0, valid}, 128'd0);
            for (int i = 0; i < 16; i++) begin
                rd_idx = IDX_W'(i);
                #0.1;
                check("rst_rd_key", rd_key, 128'd0);
            end
        end else begin
            check("busy",  {127'b0, busy},  {127'b0, (remaining > 0)});
            check("valid", {127'b0, valid}, {127'b0, m_valid});
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missing: actual 0 required 1 at cycle %0d", sbq[0].due);
                void'(sbq.pop_front());
            end
            exp_done = (sbq.size() > 0) && (sbq[0].due == cyc);
            check("done", {127'b0, done}, {127'b0, exp_done});
            if (exp_done) begin
                e = sbq.pop_front();
                expand(e.key);
                for (int i = 0; i < 16; i++) begin
                    rd_idx = IDX_W'(i);
                    #0.1;
                    want = (i <= NR) ? exp_keys[i] : 128'd0;
                    check($sformatf("rd_key[%0d]", i), rd_key, want);
                    if (e.key == KEY_A && i == 1)  check("kat_a_r1",  rd_key, KEY_A1);
                    if (e.key == KEY_A && i == 10) check("kat_a_r10", rd_key, KEY_A10);
                    if (e.key == KEY_B && i == 10) check("kat_b_r10", rd_key, KEY_B10);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] last_key;
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        build_tables();

        // Reset with random inputs
        repeat (3) begin
            start  = 1'($urandom);
            key_in = rand128();
            tick();
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick(2);

        // Single expansion of the FIPS-197 key
        key_in = KEY_A; start = 1'b1; tick();
        start = 1'b0; key_in = rand128(); tick(14);

        // Starts during expansion are ignored
        key_in = KEY_A; start = 1'b1; tick();
        start = 1'b0; key_in = rand128(); tick(2);
        start = 1'b1; key_in = rand128(); tick();
        start = 1'b0; tick(3);
        start = 1'b1; key_in = rand128(); tick();
        start = 1'b0; tick(10);

        // Reset in the middle of an expansion, then a clean run
        key_in = rand128(); start = 1'b1; tick();
        start = 1'b0; tick(4);
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; tick();
        key_in = KEY_A; start = 1'b1; tick();
        start = 1'b0; tick(14);

        // Back-to-back: start held through the DONE cycle with a second key
        key_in = KEY_A; start = 1'b1; tick();
        key_in = KEY_B; tick(NR);
        start = 1'b0; tick(14);

        // Repeat the same key while valid
        key_in = KEY_B; start = 1'b1; tick();
        start = 1'b0; tick(14);

        // Randomized traffic, with repeated keys and occasional resets
        last_key = KEY_B;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) last_key = rand128();
            key_in = last_key;
            start  = 1'b1;
            tick($urandom_range(1, 3));
            start  = 1'b0;
            key_in = rand128();
            tick($urandom_range(0, 14));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0; tick(2);
                rst_n = 1'b1; tick();
            end
        end
        tick(NR + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
